// File: rtl/dm_mmio.sv
// -----------------------------------------------------------------------------
// dm_mmio : data-memory responder for the single-cycle core.
//
// Word-addressed RAM at the bottom of the address space plus a four-register
// peripheral window at MMIO_BASE:
//   +0x0 CYCLE  : free-running 32-bit cycle counter (writable)
//   +0x4 LED    : 16-bit LED register
//   +0x8 TXDATA : write pushes a byte into the TX FIFO, reads 0
//   +0xC STATUS : {24'b0, count[3:0], 1'b0, ovf, full, empty}; write bit 2 clears ovf
// Loads are combinational from pre-edge state; stores land on the rising edge.
//
// Ports:
//   clk        clock, all state updates on rising edge
//   rst        synchronous active-high reset
//   MemWrite   store strobe from the core
//   addr       byte address (addr[1:0] ignored)
//   writedata  store data
//   readdata   load data, combinational
//   led        LED register
//   tx_data    TX FIFO head byte
//   tx_valid   TX FIFO non-empty
//   tx_ready   sink accepts the head byte this cycle
// -----------------------------------------------------------------------------
module dm_mmio #(
  parameter int          RAM_WORDS  = 128,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [15:0] led,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

  typedef enum logic [1:0] {
    REG_CYCLE  = 2'd0,
    REG_LED    = 2'd1,
    REG_TXDATA = 2'd2,
    REG_STATUS = 2'd3
  } mmio_reg_e;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic          sel_ram;
  logic          sel_mmio;
  mmio_reg_e     reg_sel;
  logic [AW-1:0] ram_idx;

  assign sel_ram  = (addr < RAM_BYTES);
  assign sel_mmio = (addr[31:4] == MMIO_BASE[31:4]);
  assign reg_sel  = mmio_reg_e'(addr[3:2]);
  assign ram_idx  = addr[AW+1:2];

  // Reset masks every store, including the RAM write.
  logic we_ram, we_cycle, we_led, we_tx, we_status;

  assign we_ram    = MemWrite & ~rst & sel_ram;
  assign we_cycle  = MemWrite & ~rst & sel_mmio & (reg_sel == REG_CYCLE);
  assign we_led    = MemWrite & ~rst & sel_mmio & (reg_sel == REG_LED);
  assign we_tx     = MemWrite & ~rst & sel_mmio & (reg_sel == REG_TXDATA);
  assign we_status = MemWrite & ~rst & sel_mmio & (reg_sel == REG_STATUS);

  // Byte-offset bits are architecturally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  // ---------------------------------------------------------------------------
  // RAM
  // ---------------------------------------------------------------------------
  logic [31:0] ram [RAM_WORDS];

  // NOTE: storage arrays carry no reset; clearing them would turn the RAM into
  // a flop bank. Software must write a word before it reads it.
  always_ff @(posedge clk) begin
    if (we_ram) ram[ram_idx] <= writedata;
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic          full, empty, pop, push;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign tx_valid = ~empty;
  assign tx_data  = fifo[rd_ptr];
  assign pop      = tx_valid & tx_ready;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push     = we_tx & (~full | pop);

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= writedata[7:0];
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  logic [31:0] cycle;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle  <= '0;
      led    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (we_cycle) cycle <= writedata;
      else          cycle <= cycle + 32'd1;

      if (we_led) led <= writedata[15:0];

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // A dropped byte and an ovf clear cannot share a cycle (one port).
      if (we_status && writedata[2]) ovf <= 1'b0;
      else if (we_tx && !push)       ovf <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [3:0] count_disp;

  assign count_disp = (32'(count) > 32'd15) ? 4'hF : 4'(count);

  // NOTE: readdata gets a default before the decode so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    readdata = '0;
    if (sel_ram) begin
      readdata = ram[ram_idx];
    end else if (sel_mmio) begin
      case (reg_sel)
        REG_CYCLE:  readdata = cycle;
        REG_LED:    readdata = {16'b0, led};
        REG_TXDATA: readdata = '0;
        REG_STATUS: readdata = {24'b0, count_disp, 1'b0, ovf, full, empty};
        default:    readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_mmio.sv
// -----------------------------------------------------------------------------
// tb_dm_mmio : self-checking bench for dm_mmio.
// Directed scenario tasks compare against hand-derived constants; a randomized
// task compares every cycle against a queue/array reference model that is
// advanced at each rising edge.
// -----------------------------------------------------------------------------
module tb_dm_mmio;

  localparam int          RAM_WORDS  = 128;
  localparam int          FIFO_DEPTH = 4;
  localparam logic [31:0] BASE       = 32'h0000_7F00;
  localparam logic [31:0] A_CYC      = BASE;
  localparam logic [31:0] A_LED      = BASE + 32'h4;
  localparam logic [31:0] A_TX       = BASE + 32'h8;
  localparam logic [31:0] A_ST       = BASE + 32'hC;
  localparam logic [31:0] A_IDLE     = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] addr = A_IDLE;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [15:0] led;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  dm_mmio #(
    .RAM_WORDS (RAM_WORDS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .MMIO_BASE (BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .MemWrite (MemWrite),
    .addr     (addr),
    .writedata(writedata),
    .readdata (readdata),
    .led      (led),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: state as plain variables, a byte queue, a sparse RAM.
  // ---------------------------------------------------------------------------
  logic [31:0] m_ram [int];
  logic [31:0] m_cnt = '0;
  logic [15:0] m_led = '0;
  logic [7:0]  m_q [$];
  logic        m_ovf = 1'b0;

  function automatic void model_edge();
    logic [31:0] w;
    bit          popped;
    int          size_before;
    w = addr & ~32'h3;
    if (rst) begin
      m_cnt = '0; m_led = '0; m_ovf = 1'b0; m_q.delete();
      return;
    end
    size_before = m_q.size();
    popped      = (size_before != 0) && tx_ready;
    if (MemWrite && w < 32'(4 * RAM_WORDS)) m_ram[int'(w >> 2)] = writedata;
    if (MemWrite && w == A_CYC) m_cnt = writedata;
    else                        m_cnt = m_cnt + 1;
    if (MemWrite && w == A_LED) m_led = writedata[15:0];
    if (popped) void'(m_q.pop_front());
    if (MemWrite && w == A_TX) begin
      if (size_before < FIFO_DEPTH || popped) m_q.push_back(writedata[7:0]);
      else                                    m_ovf = 1'b1;
    end
    if (MemWrite && w == A_ST && writedata[2]) m_ovf = 1'b0;
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] a);
    logic [31:0] w;
    int          n;
    w = a & ~32'h3;
    n = m_q.size();
    if (w < 32'(4 * RAM_WORDS)) return m_ram[int'(w >> 2)];
    if (w == A_CYC) return m_cnt;
    if (w == A_LED) return {16'b0, m_led};
    if (w == A_ST)
      return 32'((n > 15 ? 15 : n) * 16) + (m_ovf ? 32'd4 : 32'd0)
           + (n == FIFO_DEPTH ? 32'd2 : 32'd0) + (n == 0 ? 32'd1 : 32'd0);
    return 32'd0;
  endfunction

  // ---------------------------------------------------------------------------
  // Bus helpers (drive only; no checking)
  // ---------------------------------------------------------------------------
  task automatic set_bus(input logic we, input logic [31:0] a, input logic [31:0] wd);
    MemWrite  = we;
    addr      = a;
    writedata = wd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_bus(1'b0, A_IDLE, '0);
    tick();
    rst = 1'b0;
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    set_bus(1'b1, 32'h20, 32'h1111_1111);
    tick();
    // Stores during reset must be ignored, RAM included.
    rst = 1'b1;
    set_bus(1'b1, 32'h20, 32'h2222_2222);
    tick();
    set_bus(1'b1, A_LED, 32'hFFFF_FFFF);
    tick();
    rst = 1'b0;
    set_bus(1'b0, A_ST, '0);
    n_tests++; if (readdata !== 32'h01) begin n_fail++; $display("FAIL reset_status: got %h exp %h", readdata, 32'h01); end
    n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b exp 0", tx_valid); end
    n_tests++; if (led !== 16'h0) begin n_fail++; $display("FAIL reset_led_write_ignored: got %h exp 0000", led); end
    set_bus(1'b0, A_CYC, '0);
    n_tests++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_cycle: got %h exp 0", readdata); end
    set_bus(1'b0, 32'h20, '0);
    n_tests++; if (readdata !== 32'h1111_1111) begin n_fail++; $display("FAIL reset_ram_write_ignored: got %h exp 11111111", readdata); end
  endtask

  task automatic test_ram();
    do_reset();
    set_bus(1'b1, 32'h10, 32'h0);
    tick();
    set_bus(1'b1, 32'h0, 32'h0102_0304);
    tick();
    set_bus(1'b1, 32'h10, 32'hDEAD_BEEF);
    n_tests++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL ram_same_cycle_store: got %h exp 0", readdata); end
    tick();
    set_bus(1'b0, 32'h10, '0);
    n_tests++; if (readdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_load_10: got %h exp deadbeef", readdata); end
    set_bus(1'b0, 32'h13, '0);
    n_tests++; if (readdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_load_13: got %h exp deadbeef", readdata); end
    set_bus(1'b1, 32'h200, 32'h5555_AAAA);
    n_tests++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL unmapped_200: got %h exp 0", readdata); end
    tick();
    set_bus(1'b0, 32'h0, '0);
    n_tests++; if (readdata !== 32'h0102_0304) begin n_fail++; $display("FAIL unmapped_write_alias: got %h exp 01020304", readdata); end
    set_bus(1'b1, 32'h1FC, 32'hCAFE_F00D);
    tick();
    set_bus(1'b0, 32'h1FE, '0);
    n_tests++; if (readdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL ram_last_word: got %h exp cafef00d", readdata); end
    set_bus(1'b0, BASE + 32'h10, '0);
    n_tests++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL unmapped_past_window: got %h exp 0", readdata); end
  endtask

  task automatic test_cycle();
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    set_bus(1'b0, A_CYC, '0);
    n_tests++; if (readdata !== 32'd5) begin n_fail++; $display("FAIL cycle_after_5: got %h exp 5", readdata); end
    set_bus(1'b1, A_CYC, 32'hFFFF_FFFE);
    tick();
    set_bus(1'b0, A_CYC, '0);
    n_tests++; if (readdata !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL cycle_load_no_inc: got %h exp fffffffe", readdata); end
    tick();
    tick();
    tick();
    n_tests++; if (readdata !== 32'h1) begin n_fail++; $display("FAIL cycle_wrap: got %h exp 1", readdata); end
  endtask

  task automatic test_fifo_overflow();
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_bus(1'b1, A_TX, 32'h41 + 32'(i));
      tick();
    end
    set_bus(1'b0, A_ST, '0);
    n_tests++; if (readdata !== 32'h42) begin n_fail++; $display("FAIL status_full: got %h exp 42", readdata); end
    set_bus(1'b1, A_TX, 32'h45);
    tick();
    set_bus(1'b0, A_ST, '0);
    n_tests++; if (readdata !== 32'h46) begin n_fail++; $display("FAIL status_ovf: got %h exp 46", readdata); end
    n_tests++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL tx_hold: got %h exp 41", tx_data); end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin n_fail++; $display("FAIL drain_%0d: got v=%b d=%h exp v=1 d=%h", i, tx_valid, tx_data, 8'(8'h41 + i)); end
      tick();
    end
    tx_ready = 1'b0;
    n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL drained_valid: got %b exp 0", tx_valid); end
    n_tests++; if (readdata !== 32'h05) begin n_fail++; $display("FAIL status_empty_ovf: got %h exp 05", readdata); end
  endtask

  task automatic test_fifo_push_pop();
    logic [7:0] exp_bytes [4];
    exp_bytes = '{8'h42, 8'h43, 8'h44, 8'h55};
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_bus(1'b1, A_TX, 32'h41 + 32'(i));
      tick();
    end
    tx_ready = 1'b1;
    set_bus(1'b1, A_TX, 32'h55);
    n_tests++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL full_pushpop_head: got %h exp 41", tx_data); end
    tick();
    tx_ready = 1'b0;
    set_bus(1'b0, A_ST, '0);
    n_tests++; if (readdata !== 32'h46) begin n_fail++; $display("FAIL full_pushpop_status: got %h exp 46", readdata); end
    n_tests++; if (tx_data !== 8'h42) begin n_fail++; $display("FAIL full_pushpop_next: got %h exp 42", tx_data); end
    set_bus(1'b1, A_ST, 32'hFFFF_FFFB);
    tick();
    set_bus(1'b0, A_ST, '0);
    n_tests++; if (readdata !== 32'h46) begin n_fail++; $display("FAIL ovf_not_cleared_bit2_0: got %h exp 46", readdata); end
    set_bus(1'b1, A_ST, 32'h4);
    tick();
    set_bus(1'b0, A_ST, '0);
    n_tests++; if (readdata !== 32'h42) begin n_fail++; $display("FAIL ovf_clear: got %h exp 42", readdata); end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (tx_valid !== 1'b1 || tx_data !== exp_bytes[i]) begin n_fail++; $display("FAIL pushpop_drain_%0d: got v=%b d=%h exp v=1 d=%h", i, tx_valid, tx_data, exp_bytes[i]); end
      tick();
    end
    tx_ready = 1'b0;
    n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL pushpop_empty: got %b exp 0", tx_valid); end
  endtask

  task automatic test_led_reset();
    set_bus(1'b1, A_LED, 32'h1234_ABCD);
    tick();
    set_bus(1'b0, A_LED, '0);
    n_tests++; if (led !== 16'hABCD) begin n_fail++; $display("FAIL led_port: got %h exp abcd", led); end
    n_tests++; if (readdata !== 32'h0000_ABCD) begin n_fail++; $display("FAIL led_read: got %h exp 0000abcd", readdata); end
    tx_ready = 1'b0;
    set_bus(1'b1, A_TX, 32'h61);
    tick();
    set_bus(1'b1, A_TX, 32'h62);
    tick();
    set_bus(1'b0, A_ST, '0);
    n_tests++; if (readdata !== 32'h20) begin n_fail++; $display("FAIL status_two: got %h exp 20", readdata); end
    rst = 1'b1;
    set_bus(1'b1, A_TX, 32'h77);
    tick();
    rst = 1'b0;
    set_bus(1'b0, A_ST, '0);
    n_tests++; if (readdata !== 32'h01) begin n_fail++; $display("FAIL midstream_status: got %h exp 01", readdata); end
    n_tests++; if (led !== 16'h0) begin n_fail++; $display("FAIL midstream_led: got %h exp 0", led); end
    n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL midstream_valid: got %b exp 0", tx_valid); end
    set_bus(1'b0, A_CYC, '0);
    n_tests++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL midstream_cycle: got %h exp 0", readdata); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, wd, exp_rd;
      logic        we;
      int          idx;
      wd = $urandom;
      we = 1'b0;
      a  = A_IDLE;
      case ($urandom_range(0, 7))
        0: begin a = 32'($urandom_range(0, RAM_WORDS - 1)) * 4 + 32'($urandom_range(0, 3)); we = 1'b1; end
        1: begin idx = int'($urandom_range(0, RAM_WORDS - 1)); a = 32'(idx) * 4; we = !m_ram.exists(idx); end
        2: begin a = A_LED; we = 1'($urandom_range(0, 1)); end
        3, 4: begin a = A_TX + 32'($urandom_range(0, 3)); we = 1'b1; end
        5: begin a = A_ST; we = ($urandom_range(0, 3) == 0); end
        6: begin a = A_CYC; we = ($urandom_range(0, 15) == 0); end
        default: begin a = 32'h200 + 32'($urandom_range(0, 255)) * 4; we = 1'($urandom_range(0, 1)); end
      endcase
      tx_ready = ($urandom_range(0, 2) == 0);
      rst      = ($urandom_range(0, 63) == 0);
      set_bus(we, a, wd);
      if (!((a & ~32'h3) < 32'(4 * RAM_WORDS) && !m_ram.exists(int'(a >> 2)))) begin
        exp_rd = model_read(a);
        n_tests++; if (readdata !== exp_rd) begin n_fail++; $display("FAIL rand_read[%0d] addr=%h: got %h exp %h", i, a, readdata, exp_rd); end
      end
      n_tests++; if (tx_valid !== (m_q.size() != 0)) begin n_fail++; $display("FAIL rand_valid[%0d]: got %b exp %b", i, tx_valid, (m_q.size() != 0)); end
      if (m_q.size() != 0) begin
        n_tests++; if (tx_data !== m_q[0]) begin n_fail++; $display("FAIL rand_tx_data[%0d]: got %h exp %h", i, tx_data, m_q[0]); end
      end
      n_tests++; if (led !== m_led) begin n_fail++; $display("FAIL rand_led[%0d]: got %h exp %h", i, led, m_led); end
      tick();
    end
    rst      = 1'b0;
    tx_ready = 1'b0;
    set_bus(1'b0, A_IDLE, '0);
  endtask

  initial begin
    test_reset();
    test_ram();
    test_cycle();
    test_fifo_overflow();
    test_fifo_push_pop();
    test_led_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
